// File: rtl/lottery_grant_fsm_if.sv
// Request/sum inputs and grant/debug outputs of the lottery grant stage.
// The master modport belongs to whoever drives requests, the slave to the grant FSM.
interface lottery_grant_fsm_if;
  logic       r0;
  logic       r1;
  logic       r2;
  logic       r3;
  logic [3:0] s0;
  logic [4:0] s1;
  logic [5:0] s2;
  logic [5:0] s3;
  logic       rel;
  logic [3:0] grant;
  logic       busy;
  logic [5:0] point;
  logic [7:0] lfsr;

  modport master (
    output r0, r1, r2, r3, s0, s1, s2, s3, rel,
    input  grant, busy, point, lfsr
  );

  modport slave (
    input  r0, r1, r2, r3, s0, s1, s2, s3, rel,
    output grant, busy, point, lfsr
  );
endinterface

// File: rtl/lottery_grant_fsm.sv
// Lottery grant stage: draws a point in [0, s3) from a free-running LFSR, picks the
// requester whose cumulative ticket window contains it, and holds a one-hot grant.
module lottery_grant_fsm #(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         MAX_HOLD  = 16
) (
  input logic                clk,
  input logic                reset,
  lottery_grant_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [5:0]      point_q, point_d;
  logic [3:0]      grant_q, grant_d;
  logic [4:0]      hold_q, hold_d;
  logic [3:0][5:0] sum_q, sum_d;
  logic [3:0]      req_q, req_d;

  logic [3:0] r_live;
  logic [5:0] draw;
  logic [3:0] winner;
  logic       exit_grant;

  // Lowest requester whose window covers the point; with no live tickets at all,
  // fall back to plain fixed priority over the latched requesters.
  function automatic logic [3:0] pick_winner(input logic [3:0]      req,
                                             input logic [3:0][5:0] sums,
                                             input logic [5:0]      pt);
    logic [3:0] onehot;
    logic       found;
    logic       fallback;
    onehot   = '0;
    found    = 1'b0;
    fallback = (sums[3] == 6'd0);
    for (int i = 0; i < 4; i++) begin
      if (!found && req[i] && (fallback || (pt < sums[i]))) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
    return onehot;
  endfunction

  assign r_live     = {bus.r3, bus.r2, bus.r1, bus.r0};
  assign draw       = 6'((14'(lfsr_q) * 14'(bus.s3)) >> 8);
  assign winner     = pick_winner(req_q, sum_q, point_q);
  assign exit_grant = bus.rel || ((grant_q & r_live) == 4'd0) || (hold_q == HOLD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      point_q <= '0;
      grant_q <= '0;
      hold_q  <= '0;
      sum_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      point_q <= point_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      sum_q   <= sum_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    point_d = point_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    sum_d   = sum_q;
    req_d   = req_q;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      IDLE: begin
        if (|r_live) begin
          sum_d   = {bus.s3, bus.s2, {1'b0, bus.s1}, {2'b00, bus.s0}};
          req_d   = r_live;
          point_d = draw;
          state_d = SEL;
        end
      end
      SEL: begin
        // A draw that lands in no live window (inconsistent sums) simply retries.
        grant_d = winner;
        hold_d  = '0;
        state_d = (|winner) ? GRANT : IDLE;
      end
      GRANT: begin
        if (hold_q != 5'h1F) begin
          hold_d = hold_q + 5'd1;
        end
        if (exit_grant) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.grant = grant_q;
  assign bus.busy  = |grant_q;
  assign bus.point = point_q;
  assign bus.lfsr  = lfsr_q;

endmodule

// File: tb/tb_lottery_grant_fsm.sv
// Bench for lottery_grant_fsm: directed stimulus queues expected grants/points,
// a negedge monitor pops and compares each time a new grant appears.
module tb_lottery_grant_fsm;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lottery_grant_fsm_if bus ();

  lottery_grant_fsm #(
    .LFSR_SEED(8'hA5),
    .MAX_HOLD (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] g;
    logic [5:0] p;
    int         c;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  lfsr_m;
  logic        busy_prev = 1'b0;
  logic [63:0] seen = '0;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded with A5, restarts on reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] r, input logic [3:0] s0, input logic [4:0] s1,
                        input logic [5:0] s2, input logic [5:0] s3);
    {bus.r3, bus.r2, bus.r1, bus.r0} = r;
    bus.s0 = s0;
    bus.s1 = s1;
    bus.s2 = s2;
    bus.s3 = s3;
  endtask

  // Called in the IDLE cycle where the DUT will sample the request on the next edge.
  task automatic push_exp(input logic [3:0] g, input logic [5:0] s3);
    exp_t e;
    e.g = g;
    e.p = (s3 == 6'd0) ? 6'd0 : 6'((16'(lfsr_m) * 16'(s3)) >> 8);
    e.c = cyc;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_prev = 1'b0;
    end else begin
      chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
      if (bus.busy && !busy_prev) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant actual=%b required=none", bus.grant);
        end else begin
          e = expq.pop_front();
          chk("grant", 32'(bus.grant), 32'(e.g));
          chk("point", 32'(bus.point), 32'(e.p));
          chk("latency", 32'(cyc - e.c), 32'd2);
          seen[bus.point] = 1'b1;
        end
      end
      busy_prev = bus.busy;
    end
  end

  initial begin
    int n;
    int m;
    set_in(4'b0000, 4'd0, 5'd0, 6'd0, 6'd0);
    bus.rel = 1'b0;
    reset   = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_point", 32'(bus.point), 32'd0);
    chk("rst_lfsr", 32'(bus.lfsr), 32'hA5);
    @(negedge clk);
    chk("lfsr_step1", 32'(bus.lfsr), 32'h4A);
    @(negedge clk);
    chk("lfsr_step2", 32'(bus.lfsr), 32'h95);
    bus.rel = 1'b1;
    @(negedge clk);
    bus.rel = 1'b0;
    chk("rel_idle_ignored", 32'(bus.busy), 32'd0);

    // Single requester, released by rel
    @(negedge clk);
    set_in(4'b0100, 4'd0, 5'd0, 6'd7, 6'd7);
    push_exp(4'b0100, 6'd7);
    repeat (2) @(negedge clk);
    chk("single_busy", 32'(bus.busy), 32'd1);
    bus.rel = 1'b1;
    @(negedge clk);
    chk("rel_exit_grant", 32'(bus.grant), 32'd0);
    chk("rel_exit_busy", 32'(bus.busy), 32'd0);
    bus.rel = 1'b0;
    set_in(4'b0000, 4'd0, 5'd0, 6'd0, 6'd0);

    // Hold limit: grant held exactly 16 cycles, then re-drawn after IDLE, SEL
    @(negedge clk);
    set_in(4'b0001, 4'd5, 5'd5, 6'd5, 6'd5);
    push_exp(4'b0001, 6'd5);
    repeat (2) @(negedge clk);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("hold_len", 32'(n), 32'd16);
    push_exp(4'b0001, 6'd5);
    m = 0;
    while (!bus.busy && m < 10) begin
      m++;
      @(negedge clk);
    end
    chk("regrant_gap", 32'(m), 32'd2);
    set_in(4'b0000, 4'd0, 5'd0, 6'd0, 6'd0);
    @(negedge clk);
    chk("drop_r0_exit", 32'(bus.busy), 32'd0);

    // All tickets zero: fixed-priority fallback, then request drop ends grant
    @(negedge clk);
    set_in(4'b0110, 4'd0, 5'd0, 6'd0, 6'd0);
    push_exp(4'b0010, 6'd0);
    repeat (2) @(negedge clk);
    chk("fallback_busy", 32'(bus.busy), 32'd1);
    set_in(4'b0100, 4'd0, 5'd0, 6'd0, 6'd0);
    @(negedge clk);
    chk("drop_r1_exit", 32'(bus.grant), 32'd0);
    push_exp(4'b0100, 6'd0);
    repeat (2) @(negedge clk);
    chk("fallback2_grant", 32'(bus.grant), 32'b0100);

    // Async reset between edges while granted
    #2;
    reset = 1'b0;
    #1;
    chk("async_grant", 32'(bus.grant), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    set_in(4'b0000, 4'd0, 5'd0, 6'd0, 6'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_lfsr", 32'(bus.lfsr), 32'hA5);
    chk("post_rst_grant", 32'(bus.grant), 32'd0);
    @(negedge clk);
    set_in(4'b0010, 4'd0, 5'd3, 6'd3, 6'd3);
    push_exp(4'b0010, 6'd3);
    repeat (2) @(negedge clk);
    chk("post_rst_draw", 32'(bus.busy), 32'd1);
    set_in(4'b0000, 4'd0, 5'd0, 6'd0, 6'd0);
    repeat (2) @(negedge clk);

    // Zero-ticket exclusion over 200 draws; stride of 4 cycles keeps LFSR samples distinct
    seen = '0;
    for (int i = 0; i < 200; i++) begin
      set_in(4'b1010, 4'd0, 5'd0, 6'd0, 6'd9);
      push_exp(4'b1000, 6'd9);
      repeat (2) @(negedge clk);
      set_in(4'b0000, 4'd0, 5'd0, 6'd0, 6'd0);
      repeat (2) @(negedge clk);
    end
    chk("point_span", 32'(seen[8:0]), 32'h1FF);
    chk("point_range", 32'(|seen[63:9]), 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
